// File: rtl/alarm_sequencer_if.sv
// Control, pattern-write and playback signals between the alarm sequencer
// and its surroundings (nap timer, buttons, tone generator / LED driver).
interface alarm_sequencer_if #(
  parameter int NOTE_W = 13,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              start;
  logic              stop;
  logic              snooze;
  logic [AW:0]       seq_len;
  logic [7:0]        repeat_limit;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [NOTE_W-1:0] wr_note;
  logic              wr_light;
  logic [NOTE_W-1:0] beat;
  logic              light;
  logic              active;
  logic [AW-1:0]     step_idx;
  logic              done;

  // Side that commands the sequencer and consumes its outputs.
  modport master (
    output start, stop, snooze, seq_len, repeat_limit,
    output wr_en, wr_addr, wr_note, wr_light,
    input  beat, light, active, step_idx, done
  );

  // The sequencer itself.
  modport slave (
    input  start, stop, snooze, seq_len, repeat_limit,
    input  wr_en, wr_addr, wr_note, wr_light,
    output beat, light, active, step_idx, done
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: plays a programmable pattern of note codes and light
// flags at a prescaled tempo, with repeat count, stop and limited snoozes.
module alarm_sequencer #(
  parameter int NOTE_W       = 13,
  parameter int DEPTH        = 16,
  parameter int TICK_DIV     = 4,
  parameter int SNOOZE_TICKS = 8,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic              clock,
  input  logic              reset,
  alarm_sequencer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;
  localparam int UW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SNZ_INIT   = SW'(SNOOZE_TICKS - 1);
  localparam logic [UW-1:0] SNZ_MAX    = UW'(MAX_SNOOZE);
  localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_STEP  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_SNOOZE} state_t;

  // Each entry is {light, note}.
  logic [NOTE_W:0] pat_mem [DEPTH];

  state_t            state_reg, state_next;
  logic [PW-1:0]     presc_reg, presc_next;
  logic [AW-1:0]     step_reg, step_next;
  logic [AW-1:0]     len_m1_reg, len_m1_next;
  logic [7:0]        rep_reg, rep_next;
  logic [7:0]        rep_lim_reg, rep_lim_next;
  logic [SW-1:0]     snz_cnt_reg, snz_cnt_next;
  logic [UW-1:0]     snz_used_reg, snz_used_next;
  logic              snooze_prev_reg;
  logic [NOTE_W-1:0] beat_reg, beat_next;
  logic              light_reg, light_next;
  logic              active_reg, active_next;
  logic              done_reg, done_next;

  logic              tick;
  logic              snooze_rise;
  logic [AW-1:0]     step_inc;
  logic [7:0]        rep_inc;
  logic [AW-1:0]     len_m1_in;

  assign tick        = (state_reg != ST_IDLE) && (presc_reg == PRESC_LAST);
  assign snooze_rise = bus.snooze & ~snooze_prev_reg;
  assign step_inc    = step_reg + AW'(1);
  assign rep_inc     = rep_reg + 8'd1;

  // A length of zero or beyond the pattern depth plays the whole pattern.
  always_comb begin
    len_m1_in = LAST_STEP;
    if (bus.seq_len != '0 && bus.seq_len <= DEPTH_L)
      len_m1_in = AW'(bus.seq_len - 1'b1);
  end

  // Pattern storage: written in any state, cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pat_mem[i] <= '0;
    end else if (bus.wr_en) begin
      pat_mem[bus.wr_addr] <= {bus.wr_light, bus.wr_note};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      presc_reg       <= '0;
      step_reg        <= '0;
      len_m1_reg      <= '0;
      rep_reg         <= '0;
      rep_lim_reg     <= '0;
      snz_cnt_reg     <= '0;
      snz_used_reg    <= '0;
      snooze_prev_reg <= 1'b0;
      beat_reg        <= '0;
      light_reg       <= 1'b0;
      active_reg      <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      presc_reg       <= presc_next;
      step_reg        <= step_next;
      len_m1_reg      <= len_m1_next;
      rep_reg         <= rep_next;
      rep_lim_reg     <= rep_lim_next;
      snz_cnt_reg     <= snz_cnt_next;
      snz_used_reg    <= snz_used_next;
      snooze_prev_reg <= bus.snooze;
      beat_reg        <= beat_next;
      light_reg       <= light_next;
      active_reg      <= active_next;
      done_reg        <= done_next;
    end
  end

  // Next-state and output logic; priority in PLAY is stop > snooze > tick.
  always_comb begin
    state_next    = state_reg;
    presc_next    = tick ? '0 : presc_reg + PW'(1);
    step_next     = step_reg;
    len_m1_next   = len_m1_reg;
    rep_next      = rep_reg;
    rep_lim_next  = rep_lim_reg;
    snz_cnt_next  = snz_cnt_reg;
    snz_used_next = snz_used_reg;
    beat_next     = beat_reg;
    light_next    = light_reg;
    active_next   = active_reg;
    done_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        presc_next  = '0;
        beat_next   = '0;
        light_next  = 1'b0;
        active_next = 1'b0;
        if (bus.start && !bus.stop) begin
          state_next              = ST_PLAY;
          step_next               = '0;
          rep_next                = '0;
          snz_used_next           = '0;
          len_m1_next             = len_m1_in;
          rep_lim_next            = bus.repeat_limit;
          {light_next, beat_next} = pat_mem[0];
          active_next             = 1'b1;
        end
      end

      ST_PLAY: begin
        if (bus.stop) begin
          state_next  = ST_IDLE;
          beat_next   = '0;
          light_next  = 1'b0;
          active_next = 1'b0;
          step_next   = '0;
        end else if (snooze_rise && snz_used_reg < SNZ_MAX) begin
          state_next    = ST_SNOOZE;
          beat_next     = '0;
          light_next    = 1'b0;
          snz_cnt_next  = SNZ_INIT;
          snz_used_next = snz_used_reg + UW'(1);
        end else if (tick) begin
          if (step_reg != len_m1_reg) begin
            step_next               = step_inc;
            {light_next, beat_next} = pat_mem[step_inc];
          end else begin
            step_next = '0;
            rep_next  = rep_inc;
            if (rep_lim_reg != 8'd0 && rep_inc == rep_lim_reg) begin
              state_next  = ST_IDLE;
              done_next   = 1'b1;
              beat_next   = '0;
              light_next  = 1'b0;
              active_next = 1'b0;
            end else begin
              {light_next, beat_next} = pat_mem[0];
            end
          end
        end
      end

      ST_SNOOZE: begin
        if (bus.stop) begin
          state_next  = ST_IDLE;
          active_next = 1'b0;
          step_next   = '0;
        end else if (tick) begin
          if (snz_cnt_reg != '0) begin
            snz_cnt_next = snz_cnt_reg - SW'(1);
          end else begin
            state_next              = ST_PLAY;
            step_next               = '0;
            {light_next, beat_next} = pat_mem[0];
          end
        end
      end

      default: begin
        state_next  = ST_IDLE;
        beat_next   = '0;
        light_next  = 1'b0;
        active_next = 1'b0;
        step_next   = '0;
      end
    endcase

    // The prescaler restarts on every state entry.
    if (state_next != state_reg) presc_next = '0;
  end

  assign bus.beat     = beat_reg;
  assign bus.light    = light_reg;
  assign bus.active   = active_reg;
  assign bus.step_idx = step_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: stimulus pushes cycle-tagged expected
// outputs, a negedge monitor pops and compares them.
module tb_alarm_sequencer;
  localparam int NOTE_W = 13;
  localparam int DEPTH  = 16;
  localparam int TD     = 4;
  localparam int STK    = 8;
  localparam int MS     = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alarm_sequencer_if #(.NOTE_W(NOTE_W), .DEPTH(DEPTH)) bus ();

  alarm_sequencer #(
    .NOTE_W(NOTE_W), .DEPTH(DEPTH), .TICK_DIV(TD),
    .SNOOZE_TICKS(STK), .MAX_SNOOZE(MS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int                cyc;
    logic [NOTE_W-1:0] beat;
    logic              light;
    logic              active;
    logic [3:0]        step;
    logic              done;
    bit                cs;
    string             tag;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  int                cyc = 0;
  int                total = 0;
  int                bad = 0;
  bit                end_req = 1'b0;
  bit                end_done = 1'b0;
  string             cur_tag = "reset";
  logic [NOTE_W-1:0] tb_note [DEPTH];
  logic              tb_light [DEPTH];

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (mon_e.cyc != cyc) begin
        bad++;
        $display("FAIL %s missed: expected at cyc=%0d, now cyc=%0d", mon_e.tag, mon_e.cyc, cyc);
      end else if (bus.beat !== mon_e.beat || bus.light !== mon_e.light ||
                   bus.active !== mon_e.active || bus.done !== mon_e.done ||
                   (mon_e.cs && bus.step_idx !== mon_e.step)) begin
        bad++;
        $display("FAIL %s cyc=%0d got beat=%h light=%b active=%b step=%0d done=%b want beat=%h light=%b active=%b step=%0d done=%b",
                 mon_e.tag, cyc, bus.beat, bus.light, bus.active, bus.step_idx, bus.done,
                 mon_e.beat, mon_e.light, mon_e.active, mon_e.step, mon_e.done);
      end
    end
    if (end_req && !end_done) begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL leftover: got %0d unchecked entries, want 0", sb.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic push(input int c, input logic [NOTE_W-1:0] b, input logic l,
                      input logic a, input logic [3:0] s, input logic d, input bit cs);
    exp_t e;
    e.cyc = c; e.beat = b; e.light = l; e.active = a;
    e.step = s; e.done = d; e.cs = cs; e.tag = cur_tag;
    sb.push_back(e);
  endtask

  task automatic push_idle(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) push(c, '0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  // Expected playback relative to start edge e0, for offsets j0..j1.
  task automatic push_play(input int e0, input int len, input int replim,
                           input int j0, input int j1);
    int per;
    int s;
    per = len * TD;
    for (int j = j0; j <= j1; j++) begin
      if (replim != 0 && j >= replim * per) begin
        push(e0 + j, '0, 1'b0, 1'b0, 4'd0, (j == replim * per), 1'b1);
      end else begin
        s = (j / TD) % len;
        push(e0 + j, tb_note[s], tb_light[s], 1'b1, 4'(s), 1'b0, 1'b1);
      end
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step_clk(1);
  endtask

  task automatic wr(input int a, input logic [NOTE_W-1:0] n, input logic l);
    bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_note = n; bus.wr_light = l;
    step_clk(1);
    bus.wr_en = 1'b0;
    tb_note[a] = n; tb_light[a] = l;
    $display("write addr=%0d note=%h light=%b cyc=%0d", a, n, l, cyc);
  endtask

  task automatic do_start(input logic [4:0] len, input logic [7:0] rl, output int e0);
    bus.seq_len = len; bus.repeat_limit = rl; bus.start = 1'b1;
    e0 = cyc + 1;
    step_clk(1);
    bus.start = 1'b0;
    $display("start [%s] seq_len=%0d repeat_limit=%0d E0=%0d", cur_tag, len, rl, e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int ek;
    int off;
    int s;
    bus.start = 1'b0; bus.stop = 1'b0; bus.snooze = 1'b0;
    bus.seq_len = '0; bus.repeat_limit = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_note = '0; bus.wr_light = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin tb_note[i] = '0; tb_light[i] = 1'b0; end

    // Reset state.
    push_idle(1, 3);
    step_clk(4);
    reset = 1'b0;

    // Single pass.
    wr(0, 13'h0200, 1'b1);
    wr(1, 13'h0400, 1'b0);
    wr(2, 13'h1000, 1'b0);
    wr(3, 13'h0040, 1'b1);
    cur_tag = "single_pass";
    do_start(5'd4, 8'd1, e0);
    push_play(e0, 4, 1, 0, 17);
    wait_until(e0 + 18);

    // Infinite repeat, stop after two wraps.
    cur_tag = "infinite_stop";
    do_start(5'd4, 8'd0, e0);
    push_play(e0, 4, 0, 0, 37);
    wait_until(e0 + 37);
    bus.stop = 1'b1;
    step_clk(1);
    bus.stop = 1'b0;
    push_idle(e0 + 38, e0 + 40);
    wait_until(e0 + 41);

    // seq_len 0 plays full depth, two passes.
    cur_tag = "len_zero";
    do_start(5'd0, 8'd2, e0);
    push_play(e0, 16, 2, 0, 129);
    wait_until(e0 + 130);

    // seq_len beyond depth clamps to depth.
    cur_tag = "len_over";
    do_start(5'd20, 8'd1, e0);
    push_play(e0, 16, 1, 0, 65);
    wait_until(e0 + 66);

    // Three honoured snoozes, the fourth ignored.
    cur_tag = "snooze";
    do_start(5'd4, 8'd0, e0);
    ek = e0;
    for (int k = 0; k < 3; k++) begin
      off = (k == 0) ? 9 : 1;
      push_play(ek, 4, 0, 0, off);
      wait_until(ek + off);
      bus.snooze = 1'b1;
      step_clk(1);
      bus.snooze = 1'b0;
      s = ek + off + 1;
      $display("snooze %0d entered at cyc=%0d", k + 1, s);
      for (int c = s; c < s + STK * TD; c++) push(c, '0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
      ek = s + STK * TD;
    end
    cur_tag = "snooze_limit";
    push_play(ek, 4, 0, 0, 23);
    wait_until(ek + 1);
    bus.snooze = 1'b1;
    step_clk(1);
    bus.snooze = 1'b0;
    wait_until(ek + 23);
    bus.stop = 1'b1;
    step_clk(1);
    bus.stop = 1'b0;
    push_idle(ek + 24, ek + 25);
    wait_until(ek + 26);

    // start with stop in IDLE stays IDLE.
    cur_tag = "start_stop_idle";
    push_idle(cyc + 1, cyc + 3);
    bus.start = 1'b1; bus.stop = 1'b1;
    step_clk(3);
    bus.start = 1'b0; bus.stop = 1'b0;
    $display("start+stop held in IDLE until cyc=%0d", cyc);
    step_clk(1);

    // stop and snooze together in PLAY -> IDLE.
    cur_tag = "stop_snooze";
    do_start(5'd4, 8'd0, e0);
    push_play(e0, 4, 0, 0, 5);
    wait_until(e0 + 5);
    bus.stop = 1'b1; bus.snooze = 1'b1;
    step_clk(1);
    bus.stop = 1'b0; bus.snooze = 1'b0;
    push_idle(e0 + 6, e0 + 8);
    wait_until(e0 + 9);

    // Write to the playing step shows only on the next pass.
    cur_tag = "live_write";
    do_start(5'd4, 8'd0, e0);
    push_play(e0, 4, 0, 0, 15);
    wait_until(e0 + 5);
    wr(1, 13'h0001, 1'b1);
    push_play(e0, 4, 0, 16, 30);
    wait_until(e0 + 30);
    bus.stop = 1'b1;
    step_clk(1);
    bus.stop = 1'b0;
    push_idle(e0 + 31, e0 + 32);
    wait_until(e0 + 33);

    // Async reset mid-play clears outputs and pattern.
    cur_tag = "async_reset";
    do_start(5'd4, 8'd0, e0);
    push_play(e0, 4, 0, 0, 5);
    wait_until(e0 + 6);
    push_idle(e0 + 6, e0 + 8);
    #2 reset = 1'b1;
    $display("reset asserted mid-play at cyc=%0d", cyc);
    step_clk(2);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin tb_note[i] = '0; tb_light[i] = 1'b0; end
    cur_tag = "after_reset";
    do_start(5'd4, 8'd1, e0);
    push_play(e0, 4, 1, 0, 17);
    wait_until(e0 + 18);

    end_req = 1'b1;
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Parametrised successor to the nap alarm FSM. Plays a programmable pattern of one-hot note codes with a light flag, stepping at a prescaled tempo. Supports a run-time sequence length, a finite or infinite repeat count, and a limited number of snoozes. It sits between the nap timer (start), the user buttons (stop, snooze) and the tone generator / LED driver (beat, light).

Parameters:
NOTE_W, 13, width of beat (one-hot note code, not checked)
DEPTH, 16, pattern entries; power of two, >=2; AW = $clog2(DEPTH)
TICK_DIV, 4, clock cycles per pattern step; >=1
SNOOZE_TICKS, 8, silent ticks per snooze; >=1
MAX_SNOOZE, 3, snoozes honoured per alarm run; 0 disables snooze

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  level; begins an alarm run from IDLE
stop  in  1  level; aborts the run, highest priority
snooze  in  1  level; enters SNOOZE from PLAY
seq_len  in  AW+1  steps per pass; sampled on start
repeat_limit  in  8  passes per run; 0 = infinite; sampled on start
wr_en  in  1  pattern write strobe
wr_addr  in  AW  pattern write address
wr_note  in  NOTE_W  note code to write
wr_light  in  1  light flag to write
beat  out  NOTE_W  current note, registered
light  out  1  current light flag, registered
active  out  1  high in PLAY or SNOOZE
step_idx  out  AW  current step
done  out  1  one-cycle pulse when the repeat limit completes

Behaviour:
- Reset (async): state IDLE; beat=0, light=0, active=0, step_idx=0, done=0. Prescaler, repeat counter, snooze counters and all pattern entries clear to 0.
- Pattern RAM: DEPTH x (NOTE_W+1) register array, synchronous write on wr_en in any state.
  - A write to the currently playing step is not visible until that step is next loaded.
- Tick: the prescaler counts 0..TICK_DIV-1 in PLAY and SNOOZE. tick=1 when it equals TICK_DIV-1. It is held at 0 in IDLE and zeroed on every state entry.
- Length latch on start: len = seq_len. A value of 0 or >DEPTH clamps to DEPTH. repeat_limit is latched as rep_lim.
- IDLE:
  - start=1 and stop=0 -> PLAY. On the same edge: step=0, rep=0, snz_used=0, beat/light <= pattern[0], active=1.
  - start and stop both high -> stay in IDLE.
  - Outputs are 0 in IDLE.
- PLAY, priority stop > snooze > tick:
  - stop=1 -> IDLE. On that edge: beat=0, light=0, active=0, step=0. done is not pulsed.
  - snooze=1 and snz_used<MAX_SNOOZE -> SNOOZE. On that edge: beat=0, light=0, snz_cnt=SNOOZE_TICKS-1, snz_used+1.
  - snooze when snz_used==MAX_SNOOZE is ignored.
  - tick and step<len-1: step+1; beat/light <= pattern[step+1].
  - tick and step==len-1 (wrap): step=0, rep+1. If rep_lim!=0 and rep+1==rep_lim -> IDLE with done=1 for one cycle and outputs 0. Otherwise beat/light <= pattern[0].
- SNOOZE:
  - Outputs are 0; active=1.
  - stop=1 -> IDLE.
  - Each tick with snz_cnt>0: decrement.
  - Tick with snz_cnt==0 -> PLAY. On that edge: step=0, beat/light <= pattern[0], rep unchanged.
  - A held snooze level does not re-enter SNOOZE until PLAY has run at least one cycle. Implemented as rising-edge detection of snooze.
- Latency:
  - Step k is loaded on the edge E0 + k*TICK_DIV, where E0 is the edge that samples start.
  - A single-pass run of len steps ends with done high during cycle E0 + len*TICK_DIV.
- Reset mid-run: an immediate async return to the reset values. The pattern contents are cleared.

Test Plan:
- Program entries 0..3 with notes 0x0200, 0x0400, 0x1000, 0x0040 and light 1,0,0,1. Set TICK_DIV=4, seq_len=4, repeat_limit=1, pulse start -> beat follows 0x0200/0x0400/0x1000/0x0040, each for 4 cycles, light 1,0,0,1. done pulses once at E0+16; then beat=0 and active=0.
- Same program, repeat_limit=0 (infinite), stop asserted at E0+37 -> wraps at E0+16 and E0+32 to 0x0200. IDLE on the next edge with beat=0, and done never pulses.
- seq_len=0 with DEPTH=16 -> 16 steps played before wrap; step_idx reaches 15, then 0.
- Snooze pulse during step 2, SNOOZE_TICKS=8, TICK_DIV=4 -> beat=0 for 32 cycles, then resumes at step 0 with 0x0200. The 4th snooze (MAX_SNOOZE=3) is ignored and playback continues.
- start and stop high together in IDLE -> stays IDLE. stop and snooze together in PLAY -> IDLE, not SNOOZE.
- wr_en to the active step during playback -> the new note appears only on the next pass. Async reset mid-PLAY -> all outputs 0 immediately, and a subsequent start plays notes of 0.
